// File: rtl/multi_core_mem_arbiter.sv
// multi_core_mem_arbiter
//   Round-robin arbiter placing N_CORES processor data ports onto one shared
//   single-port synchronous RAM. It issues at most one registered access per
//   cycle and returns a one-cycle ack to the owning core two edges after the
//   request is sampled.
//   Optional macro ARB_GRANT_CNT_EN adds a saturating 16-bit grant counter per
//   core, read combinationally through stat_sel/stat_cnt.
module multi_core_mem_arbiter #(
   parameter int N_CORES = 2,
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_CORES-1:0]            req,
   input  logic [N_CORES-1:0]            we,
   input  logic [N_CORES*ADDR_W-1:0]     addr,
   input  logic [N_CORES*DATA_W-1:0]     wdata,
   output logic [N_CORES-1:0]            ack,
   output logic [DATA_W-1:0]             rdata,
   output logic                          ram_en,
   output logic                          ram_we,
   output logic [ADDR_W-1:0]             ram_addr,
   output logic [DATA_W-1:0]             ram_wdata,
`ifdef ARB_GRANT_CNT_EN
   input  logic [$clog2(N_CORES)-1:0]    stat_sel,
   output logic [15:0]                   stat_cnt,
`endif
   input  logic [DATA_W-1:0]             ram_rdata
);

   localparam int                IDX_W = $clog2(N_CORES);
   localparam logic [IDX_W:0]    NC    = (IDX_W+1)'(N_CORES);
   localparam logic [IDX_W-1:0]  LAST  = IDX_W'(N_CORES - 1);

   logic                 ram_en_q,    ram_en_d;
   logic                 ram_we_q,    ram_we_d;
   logic [ADDR_W-1:0]    ram_addr_q,  ram_addr_d;
   logic [DATA_W-1:0]    ram_wdata_q, ram_wdata_d;
   logic [N_CORES-1:0]   ack_q,       ack_d;
   logic [IDX_W-1:0]     gnt_idx_q,   gnt_idx_d;
   logic [IDX_W-1:0]     rr_ptr_q,    rr_ptr_d;

   logic [N_CORES-1:0]   gnt_onehot;
   logic [N_CORES-1:0]   busy;
   logic [N_CORES-1:0]   elig;
   logic                 hit;
   logic [IDX_W-1:0]     sel;
   logic                 sel_we;
   logic [ADDR_W-1:0]    sel_addr;
   logic [DATA_W-1:0]    sel_wdata;
   logic [IDX_W:0]       sum;
   logic [IDX_W-1:0]     cand;

   // Round-robin search from rr_ptr over cores that are neither in flight nor being acked
   always_comb begin
      gnt_onehot = N_CORES'(1) << gnt_idx_q;
      busy       = ack_q | (ram_en_q ? gnt_onehot : '0);
      elig       = req & ~busy;
      hit        = 1'b0;
      sel        = '0;
      sel_we     = 1'b0;
      sel_addr   = '0;
      sel_wdata  = '0;
      sum        = '0;
      cand       = '0;
      for (int k = 0; k < N_CORES; k++) begin
         sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
         if (sum >= NC) sum = sum - NC;
         cand = sum[IDX_W-1:0];
         if (!hit && elig[cand]) begin
            hit = 1'b1;
            sel = cand;
         end
      end
      for (int k = 0; k < N_CORES; k++) begin
         if (hit && sel == IDX_W'(k)) begin
            sel_we    = we[k];
            sel_addr  = addr[k*ADDR_W +: ADDR_W];
            sel_wdata = wdata[k*DATA_W +: DATA_W];
         end
      end
   end

   // Next-state: register the winning access, ack the access issued last cycle
   always_comb begin
      ram_en_d    = hit;
      ram_we_d    = hit ? sel_we    : ram_we_q;
      ram_addr_d  = hit ? sel_addr  : ram_addr_q;
      ram_wdata_d = hit ? sel_wdata : ram_wdata_q;
      gnt_idx_d   = hit ? sel       : gnt_idx_q;
      rr_ptr_d    = rr_ptr_q;
      if (hit) rr_ptr_d = (sel == LAST) ? '0 : sel + 1'b1;
      ack_d       = ram_en_q ? gnt_onehot : '0;
   end

   // Arbiter state; reset drops any in-flight access so no ack follows it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ram_en_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         ack_q       <= '0;
         gnt_idx_q   <= '0;
         rr_ptr_q    <= '0;
      end else begin
         ram_en_q    <= ram_en_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         ack_q       <= ack_d;
         gnt_idx_q   <= gnt_idx_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign ram_en    = ram_en_q;
   assign ram_we    = ram_we_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;
   assign ack       = ack_q;
   assign rdata     = ram_rdata;

`ifdef ARB_GRANT_CNT_EN
   // Counter array is padded to a power of two so stat_sel never indexes out of range;
   // padding entries are never selected and stay at zero.
   localparam int N_CNT = 2**IDX_W;

   logic [15:0] cnt_q [N_CNT];
   logic [15:0] cnt_d [N_CNT];

   // Saturating per-core grant count
   always_comb begin
      for (int k = 0; k < N_CNT; k++) begin
         cnt_d[k] = cnt_q[k];
         if (hit && sel == IDX_W'(k) && cnt_q[k] != 16'hFFFF) cnt_d[k] = cnt_q[k] + 16'd1;
      end
   end

   // Grant counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < N_CNT; k++) cnt_q[k] <= '0;
      end else begin
         for (int k = 0; k < N_CNT; k++) cnt_q[k] <= cnt_d[k];
      end
   end

   assign stat_cnt = cnt_q[stat_sel];
`endif

endmodule

// File: tb/tb_multi_core_mem_arbiter.sv
// Directed bench for multi_core_mem_arbiter: a 2-core and a 4-core instance,
// each with its own behavioural synchronous RAM.
module tb_multi_core_mem_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b0;

   logic [1:0]   req2, we2, ack2;
   logic [15:0]  addr2;
   logic [63:0]  wdata2;
   logic [31:0]  rdata2, ram_wdata2, ram_rdata2;
   logic         ram_en2, ram_we2;
   logic [7:0]   ram_addr2;

   logic [3:0]   req4, we4, ack4;
   logic [31:0]  addr4;
   logic [127:0] wdata4;
   logic [31:0]  rdata4, ram_wdata4, ram_rdata4;
   logic         ram_en4, ram_we4;
   logic [7:0]   ram_addr4;

`ifdef ARB_GRANT_CNT_EN
   logic         stat_sel2;
   logic [15:0]  stat_cnt2;
   logic [1:0]   stat_sel4;
   logic [15:0]  stat_cnt4;
`endif

   logic [31:0] mem2 [256];
   logic [31:0] mem4 [256];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   multi_core_mem_arbiter #(.N_CORES(2), .DATA_W(32), .ADDR_W(8)) u2 (
      .clk(clk), .rst(rst), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
      .ack(ack2), .rdata(rdata2), .ram_en(ram_en2), .ram_we(ram_we2),
      .ram_addr(ram_addr2), .ram_wdata(ram_wdata2),
`ifdef ARB_GRANT_CNT_EN
      .stat_sel(stat_sel2), .stat_cnt(stat_cnt2),
`endif
      .ram_rdata(ram_rdata2));

   multi_core_mem_arbiter #(.N_CORES(4), .DATA_W(32), .ADDR_W(8)) u4 (
      .clk(clk), .rst(rst), .req(req4), .we(we4), .addr(addr4), .wdata(wdata4),
      .ack(ack4), .rdata(rdata4), .ram_en(ram_en4), .ram_we(ram_we4),
      .ram_addr(ram_addr4), .ram_wdata(ram_wdata4),
`ifdef ARB_GRANT_CNT_EN
      .stat_sel(stat_sel4), .stat_cnt(stat_cnt4),
`endif
      .ram_rdata(ram_rdata4));

   // Synchronous single-port RAMs: read data valid the cycle after ram_en is sampled
   always @(posedge clk) begin
      if (ram_en2) begin
         if (ram_we2) mem2[ram_addr2] <= ram_wdata2;
         ram_rdata2 <= mem2[ram_addr2];
      end
      if (ram_en4) begin
         if (ram_we4) mem4[ram_addr4] <= ram_wdata4;
         ram_rdata4 <= mem4[ram_addr4];
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      checks++; if (ram_en2 !== 1'b0)     begin errors++; $display("FAIL rst_ram_en2 got=%b want=0", ram_en2); end
      checks++; if (ram_we2 !== 1'b0)     begin errors++; $display("FAIL rst_ram_we2 got=%b want=0", ram_we2); end
      checks++; if (ram_addr2 !== 8'h00)  begin errors++; $display("FAIL rst_ram_addr2 got=%h want=00", ram_addr2); end
      checks++; if (ram_wdata2 !== 32'h0) begin errors++; $display("FAIL rst_ram_wdata2 got=%h want=0", ram_wdata2); end
      checks++; if (ack2 !== 2'b00)       begin errors++; $display("FAIL rst_ack2 got=%b want=00", ack2); end
      checks++; if (ram_en4 !== 1'b0)     begin errors++; $display("FAIL rst_ram_en4 got=%b want=0", ram_en4); end
      checks++; if (ack4 !== 4'b0000)     begin errors++; $display("FAIL rst_ack4 got=%b want=0000", ack4); end
      step();
      step();
      rst = 1'b0;
      step();
      checks++; if (ram_en2 !== 1'b0)     begin errors++; $display("FAIL idle_ram_en2 got=%b want=0", ram_en2); end
   endtask

   task automatic test_single_read();
      req2 = 2'b01; we2 = 2'b00;
      step();
      checks++; if (ram_en2 !== 1'b1)     begin errors++; $display("FAIL rd_ram_en got=%b want=1", ram_en2); end
      checks++; if (ram_addr2 !== 8'h10)  begin errors++; $display("FAIL rd_ram_addr got=%h want=10", ram_addr2); end
      checks++; if (ram_we2 !== 1'b0)     begin errors++; $display("FAIL rd_ram_we got=%b want=0", ram_we2); end
      checks++; if (ack2 !== 2'b00)       begin errors++; $display("FAIL rd_ack_early got=%b want=00", ack2); end
      step();
      checks++; if (ack2 !== 2'b01)       begin errors++; $display("FAIL rd_ack got=%b want=01", ack2); end
      checks++; if (rdata2 !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got=%h want=deadbeef", rdata2); end
      checks++; if (ram_en2 !== 1'b0)     begin errors++; $display("FAIL rd_no_regrant got=%b want=0", ram_en2); end
      req2 = 2'b00;
      step();
      checks++; if (ack2 !== 2'b00)       begin errors++; $display("FAIL rd_ack_pulse got=%b want=00", ack2); end
   endtask

   task automatic test_write_read();
      req2 = 2'b10; we2 = 2'b10;
      step();
      checks++; if (ram_en2 !== 1'b1)          begin errors++; $display("FAIL wr_ram_en got=%b want=1", ram_en2); end
      checks++; if (ram_we2 !== 1'b1)          begin errors++; $display("FAIL wr_ram_we got=%b want=1", ram_we2); end
      checks++; if (ram_addr2 !== 8'h20)       begin errors++; $display("FAIL wr_ram_addr got=%h want=20", ram_addr2); end
      checks++; if (ram_wdata2 !== 32'h12345678) begin errors++; $display("FAIL wr_ram_wdata got=%h want=12345678", ram_wdata2); end
      step();
      checks++; if (ack2 !== 2'b10)            begin errors++; $display("FAIL wr_ack got=%b want=10", ack2); end
      req2 = 2'b00;
      step();
      req2 = 2'b10; we2 = 2'b00;
      step();
      checks++; if (ram_we2 !== 1'b0)          begin errors++; $display("FAIL wr_rd_ram_we got=%b want=0", ram_we2); end
      step();
      checks++; if (ack2 !== 2'b10)            begin errors++; $display("FAIL wr_rd_ack got=%b want=10", ack2); end
      checks++; if (rdata2 !== 32'h12345678)   begin errors++; $display("FAIL wr_rd_data got=%h want=12345678", rdata2); end
      req2 = 2'b00;
      step();
   endtask

   task automatic test_contention();
      req4 = 4'b1111; we4 = 4'b0000;
      for (int k = 0; k < 10; k++) begin
         logic [7:0]  ea;
         logic [3:0]  eack;
         logic [31:0] ed;
         step();
         ea   = 8'(8'h40 + (k % 4));
         eack = (k == 0) ? 4'b0000 : 4'(4'b0001 << ((k - 1) % 4));
         ed   = 32'hA000_0000 + 32'((k + 3) % 4);
         checks++; if (ram_en4 !== 1'b1) begin errors++; $display("FAIL cont_ram_en[%0d] got=%b want=1", k, ram_en4); end
         checks++; if (ram_addr4 !== ea) begin errors++; $display("FAIL cont_addr[%0d] got=%h want=%h", k, ram_addr4, ea); end
         checks++; if (ack4 !== eack)    begin errors++; $display("FAIL cont_ack[%0d] got=%b want=%b", k, ack4, eack); end
         if (k > 0) begin
            checks++; if (rdata4 !== ed) begin errors++; $display("FAIL cont_rdata[%0d] got=%h want=%h", k, rdata4, ed); end
         end
      end
      req4 = 4'b0000;
      step();
      checks++; if (ram_en4 !== 1'b0)   begin errors++; $display("FAIL cont_idle got=%b want=0", ram_en4); end
      checks++; if (ack4 !== 4'b0010)   begin errors++; $display("FAIL cont_last_ack got=%b want=0010", ack4); end
      step();
`ifdef ARB_GRANT_CNT_EN
      stat_sel4 = 2'd0; #1;
      checks++; if (stat_cnt4 !== 16'd3) begin errors++; $display("FAIL stat_core0 got=%0d want=3", stat_cnt4); end
      stat_sel4 = 2'd1; #1;
      checks++; if (stat_cnt4 !== 16'd3) begin errors++; $display("FAIL stat_core1 got=%0d want=3", stat_cnt4); end
      stat_sel4 = 2'd2; #1;
      checks++; if (stat_cnt4 !== 16'd2) begin errors++; $display("FAIL stat_core2 got=%0d want=2", stat_cnt4); end
`endif
   endtask

   task automatic test_regrant_guard();
      req2 = 2'b01; we2 = 2'b00;
      for (int k = 0; k < 9; k++) begin
         logic       een;
         logic [1:0] eack;
         step();
         een  = (k % 3 == 0) ? 1'b1 : 1'b0;
         eack = (k % 3 == 1) ? 2'b01 : 2'b00;
         checks++; if (ram_en2 !== een) begin errors++; $display("FAIL guard_en[%0d] got=%b want=%b", k, ram_en2, een); end
         checks++; if (ack2 !== eack)   begin errors++; $display("FAIL guard_ack[%0d] got=%b want=%b", k, ack2, eack); end
         req2 = (k % 3 == 1) ? 2'b00 : 2'b01;
      end
      req2 = 2'b00;
      step();
      step();
   endtask

   task automatic test_mid_op_reset();
      req4 = 4'b1000;
      step();
      checks++; if (ram_en4 !== 1'b1)   begin errors++; $display("FAIL mid_grant got=%b want=1", ram_en4); end
      checks++; if (ram_addr4 !== 8'h43) begin errors++; $display("FAIL mid_addr got=%h want=43", ram_addr4); end
      rst = 1'b1;
      #1;
      checks++; if (ram_en4 !== 1'b0)    begin errors++; $display("FAIL mid_en_async got=%b want=0", ram_en4); end
      checks++; if (ram_addr4 !== 8'h00) begin errors++; $display("FAIL mid_addr_async got=%h want=00", ram_addr4); end
      checks++; if (ram_wdata4 !== 32'h0) begin errors++; $display("FAIL mid_wdata_async got=%h want=0", ram_wdata4); end
      step();
      checks++; if (ack4 !== 4'b0000)    begin errors++; $display("FAIL mid_no_ack got=%b want=0000", ack4); end
`ifdef ARB_GRANT_CNT_EN
      stat_sel4 = 2'd3; #1;
      checks++; if (stat_cnt4 !== 16'd0) begin errors++; $display("FAIL stat_cleared got=%0d want=0", stat_cnt4); end
`endif
      rst = 1'b0;
      req4 = 4'b1111;
      step();
      checks++; if (ram_en4 !== 1'b1)    begin errors++; $display("FAIL post_rst_en got=%b want=1", ram_en4); end
      checks++; if (ram_addr4 !== 8'h40) begin errors++; $display("FAIL post_rst_core0 got=%h want=40", ram_addr4); end
      req4 = 4'b0000;
      step();
      checks++; if (ack4 !== 4'b0001)    begin errors++; $display("FAIL post_rst_ack got=%b want=0001", ack4); end
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach its summary");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem2[i] = 32'h0;
         mem4[i] = 32'h0;
      end
      mem2[8'h10] = 32'hDEADBEEF;
      for (int i = 0; i < 4; i++) mem4[8'h40 + i] = 32'hA000_0000 + 32'(i);
      req2 = '0; we2 = '0; addr2 = {8'h20, 8'h10}; wdata2 = {32'h12345678, 32'h0};
      req4 = '0; we4 = '0; addr4 = {8'h43, 8'h42, 8'h41, 8'h40}; wdata4 = '0;
`ifdef ARB_GRANT_CNT_EN
      stat_sel2 = 1'b0;
      stat_sel4 = 2'd0;
`endif
      #2;
      test_reset();
      test_single_read();
      test_write_read();
      test_contention();
      test_regrant_guard();
      test_mid_op_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
